// File: rtl/ioddr_checker_pkg.sv
// rtl/ioddr_checker_pkg.sv - shared FSM encoding, PRBS7 taps and width helpers for the IDDR/ODDR checker
package ioddr_checker_pkg;

  localparam logic [1:0] ST_WARMUP = 2'd0;
  localparam logic [1:0] ST_SEARCH = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  // x^7 + x^6 + 1, shifting towards the MSB
  localparam int PRBS7_TAP_A = 6;
  localparam int PRBS7_TAP_B = 5;

  function automatic int cand_width(input int max_latency);
    return $clog2(max_latency + 1) + 1;
  endfunction

  function automatic logic [6:0] prbs7_step(input logic [6:0] s);
    return {s[5:0], s[PRBS7_TAP_A] ^ s[PRBS7_TAP_B]};
  endfunction

endpackage

// File: rtl/ioddr_channel_checker.sv
// rtl/ioddr_channel_checker.sv - one lane: PRBS7 pair generator, TX history, alignment search FSM, error counter
module ioddr_channel_checker
  import ioddr_checker_pkg::*;
#(
  parameter logic [6:0] SEED          = 7'd1,
  parameter int         MAX_LATENCY   = 7,
  parameter int         LOCK_COUNT    = 32,
  parameter int         LOSS_THRESH   = 4,
  parameter int         ERR_CNT_WIDTH = 16,
  localparam int        CAND_W        = cand_width(MAX_LATENCY)
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     en,
  input  logic                     clr,
  output logic                     tx_d1,
  output logic                     tx_d2,
  input  logic                     rx_q1,
  input  logic                     rx_q2,
  output logic                     locked,
  output logic                     err,
  output logic [ERR_CNT_WIDTH-1:0] err_count,
  output logic [CAND_W-1:0]        align
);

  localparam int DEPTH  = MAX_LATENCY + 2;
  localparam int TAP_W  = CAND_W - 1;
  localparam int RUN_W  = $clog2(LOCK_COUNT + 1);
  localparam int MISS_W = $clog2(LOSS_THRESH + 1);
  localparam int WARM_W = $clog2(DEPTH + 1);

  localparam logic [TAP_W-1:0]  TAP_LAST  = TAP_W'(MAX_LATENCY);
  localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(LOCK_COUNT - 1);
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(LOSS_THRESH - 1);
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(DEPTH - 1);

  logic [6:0]               lfsr;
  logic [6:0]               lfsr_s1;
  logic [6:0]               lfsr_s2;
  logic [DEPTH-1:0]         hist1;
  logic [DEPTH-1:0]         hist2;
  logic [DEPTH-1:0]         sh1;
  logic [DEPTH-1:0]         sh2;
  logic [1:0]               state;
  logic [TAP_W-1:0]         tap;
  logic                     swap;
  logic [RUN_W-1:0]         run;
  logic [MISS_W-1:0]        miss;
  logic [WARM_W-1:0]        warm;
  logic [ERR_CNT_WIDTH-1:0] cnt;
  logic                     err_q;
  logic                     match;

  assign lfsr_s1 = prbs7_step(lfsr);
  assign lfsr_s2 = prbs7_step(lfsr_s1);

  // Bit 0 of each history vector is the registered TX output itself.
  always_comb begin
    sh1   = hist1 >> tap;
    sh2   = hist2 >> tap;
    match = 1'b0;
    if (swap)
      match = (rx_q1 == sh2[1]) && (rx_q2 == sh1[0]);
    else
      match = (rx_q1 == sh1[0]) && (rx_q2 == sh2[0]);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      lfsr  <= SEED;
      hist1 <= '0;
      hist2 <= '0;
      state <= ST_WARMUP;
      tap   <= '0;
      swap  <= 1'b0;
      run   <= '0;
      miss  <= '0;
      warm  <= '0;
    end else if (en) begin
      lfsr  <= lfsr_s2;
      hist1 <= {hist1[DEPTH-2:0], lfsr_s1[0]};
      hist2 <= {hist2[DEPTH-2:0], lfsr_s2[0]};
      case (state)
        ST_WARMUP: begin
          if (warm == WARM_LAST) state <= ST_SEARCH;
          else                   warm  <= warm + WARM_W'(1);
        end
        ST_SEARCH: begin
          if (match) begin
            if (run == RUN_LAST) begin
              state <= ST_LOCKED;
              run   <= '0;
              miss  <= '0;
            end else begin
              run <= run + RUN_W'(1);
            end
          end else begin
            run <= '0;
            if (swap) begin
              swap <= 1'b0;
              tap  <= (tap == TAP_LAST) ? '0 : tap + TAP_W'(1);
            end else begin
              swap <= 1'b1;
            end
          end
        end
        ST_LOCKED: begin
          if (match) begin
            miss <= '0;
          end else if (miss == MISS_LAST) begin
            state <= ST_SEARCH;
            tap   <= '0;
            swap  <= 1'b0;
            run   <= '0;
            miss  <= '0;
          end else begin
            miss <= miss + MISS_W'(1);
          end
        end
        default: state <= ST_WARMUP;
      endcase
    end
  end

  // Only locked-state mismatches are errors; clear beats a same-cycle error.
  always_ff @(posedge CLK) begin
    if (RST || clr) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else if (en && state == ST_LOCKED && !match) begin
      err_q <= 1'b1;
      if (cnt != '1) cnt <= cnt + ERR_CNT_WIDTH'(1);
    end
  end

  assign tx_d1     = hist1[0];
  assign tx_d2     = hist2[0];
  assign locked    = (state == ST_LOCKED);
  assign err       = err_q;
  assign err_count = cnt;
  assign align     = {tap, swap};

endmodule

// File: rtl/ioddr_multi_checker.sv
// rtl/ioddr_multi_checker.sv - multi-lane IDDR/ODDR loopback checker, one independent checker per channel
module ioddr_multi_checker
  import ioddr_checker_pkg::*;
#(
  parameter int  CHANNELS      = 4,
  parameter int  MAX_LATENCY   = 7,
  parameter int  LOCK_COUNT    = 32,
  parameter int  LOSS_THRESH   = 4,
  parameter int  ERR_CNT_WIDTH = 16,
  localparam int CAND_W        = cand_width(MAX_LATENCY)
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic                              EN,
  input  logic                              CLR,
  output logic [CHANNELS-1:0]               TX_D1,
  output logic [CHANNELS-1:0]               TX_D2,
  input  logic [CHANNELS-1:0]               RX_Q1,
  input  logic [CHANNELS-1:0]               RX_Q2,
  output logic [CHANNELS-1:0]               LOCKED,
  output logic [CHANNELS-1:0]               ERR,
  output logic [CHANNELS*ERR_CNT_WIDTH-1:0] ERR_COUNT,
  output logic [CHANNELS*CAND_W-1:0]        ALIGN
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    ioddr_channel_checker #(
      .SEED          (7'(i + 1)),
      .MAX_LATENCY   (MAX_LATENCY),
      .LOCK_COUNT    (LOCK_COUNT),
      .LOSS_THRESH   (LOSS_THRESH),
      .ERR_CNT_WIDTH (ERR_CNT_WIDTH)
    ) u_ch (
      .CLK       (CLK),
      .RST       (RST),
      .en        (EN),
      .clr       (CLR),
      .tx_d1     (TX_D1[i]),
      .tx_d2     (TX_D2[i]),
      .rx_q1     (RX_Q1[i]),
      .rx_q2     (RX_Q2[i]),
      .locked    (LOCKED[i]),
      .err       (ERR[i]),
      .err_count (ERR_COUNT[i*ERR_CNT_WIDTH +: ERR_CNT_WIDTH]),
      .align     (ALIGN[i*CAND_W +: CAND_W])
    );
  end

endmodule

// File: tb/tb_ioddr_multi_checker.sv
// tb/tb_ioddr_multi_checker.sv - directed bench for ioddr_multi_checker with modelled loopback channels
module tb_ioddr_multi_checker;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        EN  = 1'b0;
  logic        CLR = 1'b0;
  logic [3:0]  TX_D1, TX_D2, RX_Q1, RX_Q2, LOCKED, ERR;
  logic [63:0] ERR_COUNT;
  logic [15:0] ALIGN;

  logic        s_d1, s_d2, s_q1, s_q2, s_locked, s_err;
  logic [3:0]  s_cnt;
  logic [3:0]  s_align;

  int          n_tests = 0;
  int          n_fail  = 0;

  logic [3:0]  h1 [0:7];
  logic [3:0]  h2 [0:7];
  logic        delayed = 1'b0;
  logic [1:0]  m0      = 2'b00;
  logic [1:0]  mode3   = 2'd0;
  logic        inv_s   = 1'b0;

  logic [3:0]  sv_tx1, sv_tx2;
  logic [15:0] sv_align;
  logic [63:0] sv_cnt;
  logic        seen;

  always #5 CLK = ~CLK;

  ioddr_multi_checker dut (
    .CLK(CLK), .RST(RST), .EN(EN), .CLR(CLR),
    .TX_D1(TX_D1), .TX_D2(TX_D2), .RX_Q1(RX_Q1), .RX_Q2(RX_Q2),
    .LOCKED(LOCKED), .ERR(ERR), .ERR_COUNT(ERR_COUNT), .ALIGN(ALIGN)
  );

  ioddr_multi_checker #(.CHANNELS(1), .LOSS_THRESH(100), .ERR_CNT_WIDTH(4)) dut_sat (
    .CLK(CLK), .RST(RST), .EN(EN), .CLR(CLR),
    .TX_D1(s_d1), .TX_D2(s_d2), .RX_Q1(s_q1), .RX_Q2(s_q2),
    .LOCKED(s_locked), .ERR(s_err), .ERR_COUNT(s_cnt), .ALIGN(s_align)
  );

  // h*[k] holds the TX pair from k+1 cycles ago
  always @(posedge CLK) begin
    if (RST) begin
      for (int k = 0; k < 8; k++) begin
        h1[k] <= 4'h0;
        h2[k] <= 4'h0;
      end
    end else if (EN) begin
      h1[0] <= TX_D1;
      h2[0] <= TX_D2;
      for (int k = 1; k < 8; k++) begin
        h1[k] <= h1[k-1];
        h2[k] <= h2[k-1];
      end
    end
  end

  always @* begin
    RX_Q1[0] = TX_D1[0] ^ m0[1];
    RX_Q2[0] = TX_D2[0] ^ m0[0];
    RX_Q1[1] = delayed ? h1[2][1] : TX_D1[1];
    RX_Q2[1] = delayed ? h2[2][1] : TX_D2[1];
    RX_Q1[2] = delayed ? h2[5][2] : TX_D1[2];
    RX_Q2[2] = delayed ? h1[4][2] : TX_D2[2];
    case (mode3)
      2'd0:    begin RX_Q1[3] = TX_D1[3];  RX_Q2[3] = TX_D2[3];  end
      2'd1:    begin RX_Q1[3] = ~TX_D1[3]; RX_Q2[3] = ~TX_D2[3]; end
      default: begin RX_Q1[3] = 1'b0;      RX_Q2[3] = 1'b0;      end
    endcase
    s_q1 = s_d1 ^ inv_s;
    s_q2 = s_d2 ^ inv_s;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_locked(input logic [4:0] want, input int bound, input string tag);
    int i;
    i = 0;
    while ((({s_locked, LOCKED}) & want) != want && i < bound) begin
      @(negedge CLK);
      i++;
    end
    check(tag, {s_locked, LOCKED} & want, want);
  endtask

  initial begin
    EN  = 1'b1;
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    check("rst_tx_d1", TX_D1, 4'h0);
    check("rst_tx_d2", TX_D2, 4'h0);
    check("rst_locked", LOCKED, 4'h0);
    check("rst_err", ERR, 4'h0);
    check("rst_err_count", ERR_COUNT, 64'h0);
    check("rst_align", ALIGN, 16'h0);
    RST = 1'b0;

    wait_locked(5'h1f, 43, "lock_loopback");
    check("align_loopback", ALIGN, 16'h0);
    repeat (10000) @(negedge CLK);
    check("errcnt_loopback", ERR_COUNT, 64'h0);
    check("err_loopback", ERR, 4'h0);
    check("sat_errcnt_loopback", s_cnt, 4'h0);

    RST = 1'b1;
    delayed = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    wait_locked(5'h1f, 2000, "lock_delayed");
    check("align_delayed", ALIGN, 16'h0B60);
    repeat (200) @(negedge CLK);
    check("errcnt_delayed", ERR_COUNT, 64'h0);

    m0 = 2'b01;
    @(negedge CLK);
    m0 = 2'b00;
    repeat (20) @(negedge CLK);
    m0 = 2'b11;
    @(negedge CLK);
    m0 = 2'b00;
    @(negedge CLK);
    check("ch0_errcnt", ERR_COUNT[15:0], 64'd2);
    check("ch0_err", ERR, 4'b0001);
    check("ch0_locked", LOCKED, 4'hf);
    CLR = 1'b1;
    @(negedge CLK);
    CLR = 1'b0;
    check("clr_errcnt", ERR_COUNT, 64'h0);
    check("clr_err", ERR, 4'h0);
    check("clr_locked", LOCKED, 4'hf);

    inv_s = 1'b1;
    repeat (30) @(negedge CLK);
    check("sat_errcnt", s_cnt, 4'hf);
    check("sat_locked", s_locked, 1'b1);
    repeat (5) @(negedge CLK);
    check("sat_nowrap", s_cnt, 4'hf);
    inv_s = 1'b0;

    mode3 = 2'd1;
    repeat (3) @(negedge CLK);
    check("ch3_locked_3miss", LOCKED[3], 1'b1);
    @(negedge CLK);
    check("ch3_errcnt_loss", ERR_COUNT[63:48], 64'd4);
    check("ch3_locked_loss", LOCKED, 4'h7);
    check("ch3_align_loss", ALIGN[15:12], 64'h0);
    mode3 = 2'd2;
    seen = 1'b0;
    repeat (300) begin
      @(negedge CLK);
      if (LOCKED[3]) seen = 1'b1;
    end
    check("ch3_stuck_norelock", seen, 1'b0);
    mode3 = 2'd0;
    wait_locked(5'h1f, 300, "ch3_relock");
    check("ch3_keep_errcnt", ERR_COUNT, {16'd4, 48'd0});
    check("ch3_relock_align", ALIGN, 16'h0B60);

    sv_tx1   = TX_D1;
    sv_tx2   = TX_D2;
    sv_align = ALIGN;
    sv_cnt   = ERR_COUNT;
    EN = 1'b0;
    repeat (50) @(negedge CLK);
    check("hold_tx_d1", TX_D1, sv_tx1);
    check("hold_tx_d2", TX_D2, sv_tx2);
    check("hold_align", ALIGN, sv_align);
    check("hold_errcnt", ERR_COUNT, sv_cnt);
    EN = 1'b1;
    repeat (100) @(negedge CLK);
    check("resume_errcnt", ERR_COUNT, sv_cnt);
    check("resume_locked", LOCKED, 4'hf);

    RST = 1'b1;
    @(negedge CLK);
    check("mid_rst_tx", {TX_D1, TX_D2}, 8'h00);
    check("mid_rst_locked", LOCKED, 4'h0);
    check("mid_rst_err", ERR, 4'h0);
    check("mid_rst_errcnt", ERR_COUNT, 64'h0);
    check("mid_rst_align", ALIGN, 16'h0);
    RST = 1'b0;
    wait_locked(5'h1f, 2000, "relock_after_rst");
    check("relock_align", ALIGN, sv_align);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
